// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_resp;
    logic [1:0]  dmem_byte_enable;

    modport master (
        output dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage control: drives the data-memory handshake, sequences LDI/STI
// double accesses, formats load data and stalls the pipeline while busy.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [2:0]         mem_op,
    input  logic [15:0]        address_in,
    input  logic [15:0]        store_data,
    mem_access_stage_if.master dmem,
    output logic [15:0]        load_data,
    output logic               stall,
    output logic               timeout
);
    localparam int unsigned   CW        = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_WAIT);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LDW  = 3'd1,
        OP_LDB  = 3'd2,
        OP_STW  = 3'd3,
        OP_STB  = 3'd4,
        OP_LDI  = 3'd5,
        OP_STI  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        IND_FETCH,
        IND_FINAL
    } state_t;

    state_t        state, state_next;
    op_t           op;
    logic [15:1]   ind_addr;
    logic [CW-1:0] wait_count;
    logic [15:0]   word_addr;
    logic [7:0]    load_byte;

    assign op        = op_t'(mem_op);
    assign word_addr = {address_in[15:1], 1'b0};
    assign load_byte = address_in[0] ? dmem.dmem_rdata[15:8] : dmem.dmem_rdata[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ind_addr   <= '0;
            wait_count <= '0;
            timeout    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IND_FETCH && dmem.dmem_resp)
                ind_addr <= dmem.dmem_rdata[15:1];
            // Saturating watchdog; the flag is sticky and never aborts the access.
            if (state == IDLE || dmem.dmem_resp) begin
                wait_count <= '0;
            end else if (wait_count != MAX_COUNT) begin
                wait_count <= wait_count + 1'b1;
                if (wait_count == MAX_COUNT - 1'b1)
                    timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next            = state;
        stall                 = 1'b0;
        load_data             = '0;
        dmem.dmem_address     = '0;
        dmem.dmem_wdata       = '0;
        dmem.dmem_read        = 1'b0;
        dmem.dmem_write       = 1'b0;
        dmem.dmem_byte_enable = '0;

        case (state)
            IDLE: begin
                if (valid_in && op != OP_NONE && op != OP_RSVD) begin
                    stall      = 1'b1;
                    state_next = (op == OP_LDI || op == OP_STI) ? IND_FETCH : ACCESS;
                end
            end

            ACCESS: begin
                dmem.dmem_address = (op == OP_LDB || op == OP_STB) ? address_in : word_addr;
                stall             = !dmem.dmem_resp;
                case (op)
                    OP_LDW, OP_LDB: begin
                        dmem.dmem_read        = 1'b1;
                        dmem.dmem_byte_enable = 2'b11;
                    end
                    OP_STW: begin
                        dmem.dmem_write       = 1'b1;
                        dmem.dmem_wdata       = store_data;
                        dmem.dmem_byte_enable = 2'b11;
                    end
                    OP_STB: begin
                        dmem.dmem_write       = 1'b1;
                        dmem.dmem_wdata       = {store_data[7:0], store_data[7:0]};
                        dmem.dmem_byte_enable = address_in[0] ? 2'b10 : 2'b01;
                    end
                    default: ;
                endcase
                if (dmem.dmem_resp) begin
                    state_next = IDLE;
                    if (op == OP_LDW)
                        load_data = dmem.dmem_rdata;
                    else if (op == OP_LDB)
                        load_data = {{8{load_byte[7]}}, load_byte};
                end
            end

            IND_FETCH: begin
                dmem.dmem_address     = word_addr;
                dmem.dmem_read        = 1'b1;
                dmem.dmem_byte_enable = 2'b11;
                stall                 = 1'b1;
                if (dmem.dmem_resp)
                    state_next = IND_FINAL;
            end

            IND_FINAL: begin
                dmem.dmem_address     = {ind_addr, 1'b0};
                dmem.dmem_byte_enable = 2'b11;
                stall                 = !dmem.dmem_resp;
                if (op == OP_STI) begin
                    dmem.dmem_write = 1'b1;
                    dmem.dmem_wdata = store_data;
                end else begin
                    dmem.dmem_read = 1'b1;
                end
                if (dmem.dmem_resp) begin
                    state_next = IDLE;
                    if (op == OP_LDI)
                        load_data = dmem.dmem_rdata;
                end
            end

            default: state_next = IDLE;
        endcase

        // IDLE with a live op would otherwise stall while reset is held.
        if (!reset)
            stall = 1'b0;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a per-instruction access model.
module tb_mem_access_stage;
    localparam int unsigned MAX_WAIT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [2:0]  mem_op;
    logic [15:0] address_in;
    logic [15:0] store_data;
    logic [15:0] load_data;
    logic        stall;
    logic        timeout;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .mem_op     (mem_op),
        .address_in (address_in),
        .store_data (store_data),
        .dmem       (dmem_bus),
        .load_data  (load_data),
        .stall      (stall),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic        chk_en = 1'b0;
    logic        e_stall, e_read, e_write, e_last, e_to;
    logic [15:0] e_addr, e_wdata, e_ld;
    logic [1:0]  e_be;
    logic [15:0] lst_ld, lst_addr, lst_wdata;
    logic [1:0]  lst_be;

    int unsigned run_len = 0;
    logic        sticky  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Single compare process: outputs sampled mid-cycle against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 16'(stall), 16'(e_stall));
            check("read", 16'(dmem_bus.dmem_read), 16'(e_read));
            check("write", 16'(dmem_bus.dmem_write), 16'(e_write));
            check("timeout", 16'(timeout), 16'(e_to));
            if (e_read || e_write) begin
                check("address", dmem_bus.dmem_address, e_addr);
                check("byte_enable", 16'(dmem_bus.dmem_byte_enable), 16'(e_be));
            end
            if (e_write)
                check("wdata", dmem_bus.dmem_wdata, e_wdata);
            if (e_last) begin
                check("load_data", load_data, e_ld);
                lst_ld    = load_data;
                lst_addr  = dmem_bus.dmem_address;
                lst_wdata = dmem_bus.dmem_wdata;
                lst_be    = dmem_bus.dmem_byte_enable;
            end
        end
    end

    task automatic set_exp(input logic st, input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, input logic [1:0] be, input logic last,
                           input logic [15:0] ld);
        e_stall = st; e_read = rd; e_write = wr; e_addr = a;
        e_wdata = wd; e_be = be; e_last = last; e_ld = ld;
    endtask

    // One clock: drive memory side, then advance the watchdog model by the cycle just spent.
    task automatic cyc(input logic busy, input logic resp, input logic [15:0] rd);
        dmem_bus.dmem_resp  = resp;
        dmem_bus.dmem_rdata = rd;
        e_to                = sticky;
        @(posedge clk);
        if (busy && !resp) begin
            if (run_len < MAX_WAIT) run_len++;
            if (run_len >= MAX_WAIT) sticky = 1'b1;
        end else begin
            run_len = 0;
        end
        #1;
    endtask

    task automatic access(input logic [15:0] ea, input logic rd, input logic wr,
                          input logic [15:0] wd, input logic [1:0] be, input int unsigned waits,
                          input logic [15:0] rdata, input logic last, input logic [15:0] ld);
        for (int unsigned i = 0; i < waits; i++) begin
            set_exp(1'b1, rd, wr, ea, wd, be, 1'b0, 16'h0);
            cyc(1'b1, 1'b0, 16'($urandom));
        end
        set_exp(!last, rd, wr, ea, wd, be, last, ld);
        cyc(1'b1, 1'b1, rdata);
    endtask

    function automatic logic [15:0] byte_load(input logic [15:0] a, input logic [15:0] r);
        int unsigned b;
        b = a[0] ? (int'(r) / 256) : (int'(r) % 256);
        return (b >= 128) ? 16'(b + 16'hFF00) : 16'(b);
    endfunction

    task automatic run_instr(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd,
                             input int unsigned w1, input logic [15:0] r1,
                             input int unsigned w2, input logic [15:0] r2, input logic v);
        logic        live, is_load;
        logic [15:0] ea, wd, ld;
        logic [1:0]  be;
        valid_in = v; mem_op = op; address_in = a; store_data = sd;
        live = v && (op inside {[3'd1:3'd6]});
        set_exp(live, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
        cyc(1'b0, 1'($urandom % 2), 16'($urandom));
        if (!live) return;
        is_load = (op == 3'd1 || op == 3'd2 || op == 3'd5);
        if (op == 3'd5 || op == 3'd6) begin
            access(a & 16'hFFFE, 1'b1, 1'b0, 16'h0, 2'b11, w1, r1, 1'b0, 16'h0);
            access(r1 & 16'hFFFE, is_load, !is_load, sd, 2'b11, w2, r2, 1'b1,
                   is_load ? r2 : 16'h0);
        end else begin
            ea = (op == 3'd2 || op == 3'd4) ? a : (a & 16'hFFFE);
            be = (op == 3'd4) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            wd = (op == 3'd4) ? {sd[7:0], sd[7:0]} : sd;
            ld = (op == 3'd1) ? r1 : (op == 3'd2) ? byte_load(a, r1) : 16'h0;
            access(ea, is_load, !is_load, wd, be, w1, r1, 1'b1, ld);
        end
    endtask

    task automatic random_instrs(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            run_instr(3'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 3), 16'($urandom),
                      $urandom_range(0, 3), 16'($urandom), ($urandom % 8) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got expired expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; valid_in = 1'b0; mem_op = 3'd0; address_in = 16'h0; store_data = 16'h0;
        dmem_bus.dmem_rdata = 16'h0; dmem_bus.dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 16'(stall), 16'h0);
        check("reset_read", 16'(dmem_bus.dmem_read), 16'h0);
        check("reset_timeout", 16'(timeout), 16'h0);
        check("reset_load_data", load_data, 16'h0);
        reset = 1'b1;

        // LDW abandoned by reset in the middle of its access.
        valid_in = 1'b1; mem_op = 3'd1; address_in = 16'h3001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_read", 16'(dmem_bus.dmem_read), 16'h1);
        check("mid_stall", 16'(stall), 16'h1);
        #2 reset = 1'b0;
        #1;
        check("rst_read", 16'(dmem_bus.dmem_read), 16'h0);
        check("rst_write", 16'(dmem_bus.dmem_write), 16'h0);
        check("rst_stall", 16'(stall), 16'h0);
        check("rst_address", dmem_bus.dmem_address, 16'h0);
        check("rst_wdata", dmem_bus.dmem_wdata, 16'h0);
        check("rst_be", 16'(dmem_bus.dmem_byte_enable), 16'h0);
        check("rst_load_data", load_data, 16'h0);
        check("rst_timeout", 16'(timeout), 16'h0);
        valid_in = 1'b0; mem_op = 3'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 16'hDEAD;
        @(negedge clk);
        check("stale_read", 16'(dmem_bus.dmem_read), 16'h0);
        check("stale_stall", 16'(stall), 16'h0);
        @(posedge clk); #1;
        dmem_bus.dmem_resp = 1'b0;
        @(negedge clk);
        check("stale_after_read", 16'(dmem_bus.dmem_read), 16'h0);
        check("stale_after_write", 16'(dmem_bus.dmem_write), 16'h0);
        @(posedge clk); #1;
        chk_en = 1'b1;

        run_instr(3'd1, 16'h3001, 16'h0, 2, 16'hBEEF, 0, 16'h0, 1'b1);
        check("lit_ldw_data", lst_ld, 16'hBEEF);
        check("lit_ldw_addr", lst_addr, 16'h3000);
        run_instr(3'd2, 16'h4001, 16'h0, 1, 16'h80AA, 0, 16'h0, 1'b1);
        check("lit_ldb_hi", lst_ld, 16'hFF80);
        run_instr(3'd2, 16'h4000, 16'h0, 0, 16'h80AA, 0, 16'h0, 1'b1);
        check("lit_ldb_lo", lst_ld, 16'hFFAA);
        run_instr(3'd4, 16'h5001, 16'h1234, 2, 16'hFFFF, 0, 16'h0, 1'b1);
        check("lit_stb_wdata", lst_wdata, 16'h3434);
        check("lit_stb_be", 16'(lst_be), 16'h2);
        check("lit_stb_load", lst_ld, 16'h0);
        run_instr(3'd5, 16'h6000, 16'h0, 1, 16'h7002, 2, 16'h0042, 1'b1);
        check("lit_ldi_addr", lst_addr, 16'h7002);
        check("lit_ldi_data", lst_ld, 16'h0042);
        run_instr(3'd3, 16'h0F0F, 16'hA5A5, 0, 16'h0, 0, 16'h0, 1'b1);
        run_instr(3'd7, 16'h1111, 16'h0, 0, 16'h0, 0, 16'h0, 1'b1);
        run_instr(3'd1, 16'h2222, 16'h0, 0, 16'h0, 0, 16'h0, 1'b0);
        run_instr(3'd6, 16'h8003, 16'h5A5A, 0, 16'h9001, 0, 16'h0, 1'b1);

        random_instrs(150);

        check("pre_timeout", 16'(timeout), 16'h0);
        run_instr(3'd6, 16'h2222, 16'hCAFE, 0, 16'h1235, MAX_WAIT + 3, 16'h0, 1'b1);
        check("lit_timeout", 16'(timeout), 16'h1);
        random_instrs(20);
        check("lit_timeout_sticky", 16'(timeout), 16'h1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
